// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - shared opcodes, enums and entry struct for the immediate-decode stage
package imm_pkg;

  // Widest supported datapath; entries are stored at this width and narrowed at the ports.
  localparam int XLEN_MAX = 64;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  typedef struct packed {
    logic [31:0]         ins;
    logic [XLEN_MAX-1:0] pc;
    logic [XLEN_MAX-1:0] imm;
    imm_type_e           imm_type;
    logic                illegal;
  } entry_t;

endpackage

// File: rtl/imm_decode_comb.sv
// rtl/imm_decode_comb.sv - combinational RISC-V immediate decoder
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ENABLE_ZIMM = 1'b1
) (
  input  logic [31:0]     ins_i,
  output logic [XLEN-1:0] imm_o,
  output imm_type_e       imm_type_o,
  output logic            illegal_o
);

  logic [31:0] imm32;

  // funct3[1:0] never selects an immediate format.
  logic unused_funct3_lo;
  assign unused_funct3_lo = ^ins_i[13:12];

  // Build a 32-bit immediate per format; every format is a signed 32-bit value
  // (zimm and NONE have bit 31 clear), so one sign-extension covers XLEN=64.
  always_comb begin
    imm32      = 32'd0;
    imm_type_o = IMM_NONE;
    illegal_o  = 1'b0;
    case (ins_i[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: begin
        imm32      = {{20{ins_i[31]}}, ins_i[31:20]};
        imm_type_o = IMM_I;
      end
      OPC_STORE: begin
        imm32      = {{20{ins_i[31]}}, ins_i[31:25], ins_i[11:7]};
        imm_type_o = IMM_S;
      end
      OPC_BRANCH: begin
        imm32      = {{19{ins_i[31]}}, ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0};
        imm_type_o = IMM_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm32      = {ins_i[31:12], 12'd0};
        imm_type_o = IMM_U;
      end
      OPC_JAL: begin
        imm32      = {{11{ins_i[31]}}, ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0};
        imm_type_o = IMM_J;
      end
      OPC_SYSTEM: begin
        if (ENABLE_ZIMM && ins_i[14]) begin
          imm32      = {27'd0, ins_i[19:15]};
          imm_type_o = IMM_Z;
        end else begin
          imm32      = {{20{ins_i[31]}}, ins_i[31:20]};
          imm_type_o = IMM_I;
        end
      end
      OPC_OP: begin
        imm_type_o = IMM_NONE;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

  assign imm_o = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - registered immediate-decode stage with 2-entry skid buffer
module imm_decode_stage
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit ENABLE_ZIMM = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_ins,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_ins,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_imm_type,
  output logic            out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_check
    $error("imm_decode_stage: XLEN must be 32 or 64");
  end

  state_e          state_q, state_d;
  entry_t          main_q, main_d;
  entry_t          skid_q, skid_d;
  logic            in_ready_q, in_ready_d;
  entry_t          new_entry;
  logic [XLEN-1:0] dec_imm;
  imm_type_e       dec_type;
  logic            dec_illegal;
  logic            accept;
  logic            xfer;

  imm_decode_comb #(
    .XLEN       (XLEN),
    .ENABLE_ZIMM(ENABLE_ZIMM)
  ) u_dec (
    .ins_i     (in_ins),
    .imm_o     (dec_imm),
    .imm_type_o(dec_type),
    .illegal_o (dec_illegal)
  );

  // Pack the freshly decoded instruction into a full-width entry.
  always_comb begin
    new_entry          = '0;
    new_entry.ins      = in_ins;
    new_entry.pc       = XLEN_MAX'(in_pc);
    new_entry.imm      = XLEN_MAX'(dec_imm);
    new_entry.imm_type = dec_type;
    new_entry.illegal  = dec_illegal;
  end

  // in_ready is gated by rst so upstream sees 0 for the whole reset window.
  assign in_ready  = in_ready_q & rst;
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  // Next state and skid-buffer moves; main always drains before skid to keep order.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            main_d  = new_entry;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (accept && xfer) begin
            main_d = new_entry;
          end else if (accept) begin
            skid_d  = new_entry;
            state_d = ST_FULL;
          end else if (xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (xfer) begin
            main_d  = skid_q;
            state_d = ST_BUSY;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // State, ready and entry registers; reset clears both entries.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_ins      = main_q.ins;
  assign out_pc       = main_q.pc[XLEN-1:0];
  assign out_imm      = main_q.imm[XLEN-1:0];
  assign out_imm_type = main_q.imm_type;
  assign out_illegal  = main_q.illegal;

  // High halves of stored pc/imm are only meaningful when XLEN is the maximum.
  if (XLEN < XLEN_MAX) begin : g_narrow
    logic unused_hi;
    assign unused_hi = ^{main_q.pc[XLEN_MAX-1:XLEN], main_q.imm[XLEN_MAX-1:XLEN]};
  end

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - directed self-checking bench for imm_decode_stage
module tb_imm_decode_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_ins;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_ins32, out_pc32, out_imm32;
  logic [2:0]  out_type32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [31:0] out_ins64;
  logic [63:0] out_pc64, out_imm64, in_pc64;
  logic [2:0]  out_type64;

  int total;
  int bad;

  assign in_pc64 = {32'h0000_0001, in_pc};

  imm_decode_stage #(.XLEN(32), .ENABLE_ZIMM(1'b1)) u32 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(out_valid32), .out_ready(out_ready), .out_ins(out_ins32), .out_pc(out_pc32),
    .out_imm(out_imm32), .out_imm_type(out_type32), .out_illegal(out_illegal32)
  );

  imm_decode_stage #(.XLEN(64), .ENABLE_ZIMM(1'b1)) u64 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_ins(in_ins), .in_pc(in_pc64),
    .out_valid(out_valid64), .out_ready(out_ready), .out_ins(out_ins64), .out_pc(out_pc64),
    .out_imm(out_imm64), .out_imm_type(out_type64), .out_illegal(out_illegal64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ins = 32'h0; in_pc = 32'h0; out_ready = 1'b0;
    tick; tick;
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid32); end
    total++; if (in_ready32 !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready32); end
    total++; if ({out_ins32, out_pc32, out_imm32, out_type32, out_illegal32} !== 100'h0) begin
      bad++; $display("FAIL reset_outs32 ins=%h pc=%h imm=%h type=%0d ill=%b want all 0", out_ins32, out_pc32, out_imm32, out_type32, out_illegal32);
    end
    total++; if ({out_pc64, out_imm64} !== 128'h0) begin bad++; $display("FAIL reset_outs64 pc=%h imm=%h want 0", out_pc64, out_imm64); end
    rst = 1'b1;
    #1;
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL reset_release_in_ready got=%b want=1", in_ready32); end
  endtask

  task automatic test_decode;
    logic [31:0] v_ins  [13] = '{32'hFFF00093, 32'h80000063, 32'h800000EF, 32'h800000B7, 32'h0002D073,
                                 32'h0000007F, 32'h00A00423, 32'h00B50533, 32'h34011073, 32'h12345097,
                                 32'h80002083, 32'hFE000FA3, 32'h00008067};
    logic [63:0] v_imm  [13] = '{64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFF000, 64'hFFFFFFFFFFF00000, 64'hFFFFFFFF80000000,
                                 64'h5, 64'h0, 64'h8, 64'h0, 64'h340, 64'h12345000,
                                 64'hFFFFFFFFFFFFF800, 64'hFFFFFFFFFFFFFFFF, 64'h0};
    logic [2:0]  v_type [13] = '{3'd1, 3'd3, 3'd5, 3'd4, 3'd6, 3'd0, 3'd2, 3'd0, 3'd1, 3'd4, 3'd1, 3'd2, 3'd1};
    logic        v_ill  [13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_ins = v_ins[i]; in_pc = 32'h1000 + 32'(i * 4); out_ready = 1'b1;
      tick;
      in_valid = 1'b0;
      total++; if (out_valid32 !== 1'b1 || out_valid64 !== 1'b1) begin
        bad++; $display("FAIL dec_valid[%0d] got=%b/%b want=1/1", i, out_valid32, out_valid64);
      end
      total++; if (out_imm32 !== v_imm[i][31:0]) begin bad++; $display("FAIL dec_imm32[%0d] got=%h want=%h", i, out_imm32, v_imm[i][31:0]); end
      total++; if (out_imm64 !== v_imm[i]) begin bad++; $display("FAIL dec_imm64[%0d] got=%h want=%h", i, out_imm64, v_imm[i]); end
      total++; if (out_type32 !== v_type[i] || out_type64 !== v_type[i]) begin
        bad++; $display("FAIL dec_type[%0d] got=%0d/%0d want=%0d", i, out_type32, out_type64, v_type[i]);
      end
      total++; if (out_illegal32 !== v_ill[i] || out_illegal64 !== v_ill[i]) begin
        bad++; $display("FAIL dec_illegal[%0d] got=%b/%b want=%b", i, out_illegal32, out_illegal64, v_ill[i]);
      end
      total++; if (out_ins32 !== v_ins[i] || out_pc32 !== 32'h1000 + 32'(i * 4) || out_pc64 !== {32'h1, 32'h1000 + 32'(i * 4)}) begin
        bad++; $display("FAIL dec_ins_pc[%0d] ins=%h pc=%h pc64=%h want ins=%h pc=%h", i, out_ins32, out_pc32, out_pc64, v_ins[i], 32'h1000 + 32'(i * 4));
      end
    end
    tick;
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL dec_drain_valid got=%b want=0", out_valid32); end
  endtask

  task automatic test_backpressure;
    logic [31:0] e_ins [3] = '{32'hFFF00093, 32'h80000063, 32'h800000EF};
    logic [31:0] e_imm [3] = '{32'hFFFFFFFF, 32'hFFFFF000, 32'hFFF00000};
    out_ready = 1'b0;
    in_valid = 1'b1; in_ins = e_ins[0]; in_pc = 32'h2000;
    tick;
    total++; if (in_ready32 !== 1'b1 || out_ins32 !== e_ins[0]) begin
      bad++; $display("FAIL bp_first rdy=%b ins=%h want rdy=1 ins=%h", in_ready32, out_ins32, e_ins[0]);
    end
    in_ins = e_ins[1]; in_pc = 32'h2004;
    tick;
    total++; if (in_ready32 !== 1'b0 || in_ready64 !== 1'b0) begin
      bad++; $display("FAIL bp_full_ready got=%b/%b want=0/0", in_ready32, in_ready64);
    end
    in_ins = e_ins[2]; in_pc = 32'h2008;
    tick;
    total++; if (out_valid32 !== 1'b1 || out_ins32 !== e_ins[0] || out_imm32 !== e_imm[0] || out_pc32 !== 32'h2000 || in_ready32 !== 1'b0) begin
      bad++; $display("FAIL bp_stall_stable valid=%b ins=%h imm=%h pc=%h rdy=%b want 1/%h/%h/00002000/0",
                      out_valid32, out_ins32, out_imm32, out_pc32, in_ready32, e_ins[0], e_imm[0]);
    end
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      tick;
      total++; if (out_valid32 !== 1'b1 || out_ins32 !== e_ins[k] || out_imm32 !== e_imm[k] || out_pc32 !== 32'h2000 + 32'(k * 4)) begin
        bad++; $display("FAIL bp_order[%0d] valid=%b ins=%h imm=%h pc=%h want ins=%h imm=%h", k, out_valid32, out_ins32, out_imm32, out_pc32, e_ins[k], e_imm[k]);
      end
      if (k == 2) in_valid = 1'b0;
    end
    tick;
    total++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
      bad++; $display("FAIL bp_drain valid=%b rdy=%b want 0/1", out_valid32, in_ready32);
    end
  endtask

  task automatic test_flush;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ins = 32'h00A00423; in_pc = 32'h3000; tick;
    in_ins = 32'h12345097; in_pc = 32'h3004; tick;
    in_ins = 32'h80002083; in_pc = 32'h3008; flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0) begin
      bad++; $display("FAIL flush_full valid=%b rdy=%b valid64=%b want 0/1/0", out_valid32, in_ready32, out_valid64);
    end
    out_ready = 1'b1;
    tick; tick;
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL flush_no_reappear got=%b want=0", out_valid32); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_ins = 32'h800000EF; in_pc = 32'h3010; tick;
    in_ins = 32'h0002D073; in_pc = 32'h3014; flush = 1'b1;
    tick;
    flush = 1'b0; in_valid = 1'b0;
    total++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1) begin
      bad++; $display("FAIL flush_busy_accept valid=%b rdy=%b want 0/1", out_valid32, in_ready32);
    end
  endtask

  task automatic test_reset_full;
    out_ready = 1'b0;
    in_valid = 1'b1; in_ins = 32'hFFF00093; in_pc = 32'h4000; tick;
    in_ins = 32'h80000063; in_pc = 32'h4004; tick;
    in_valid = 1'b0; rst = 1'b0;
    tick;
    total++; if (out_valid32 !== 1'b0 || in_ready32 !== 1'b0 || out_ins32 !== 32'h0 || out_imm32 !== 32'h0 || out_pc32 !== 32'h0) begin
      bad++; $display("FAIL rst_full valid=%b rdy=%b ins=%h imm=%h pc=%h want 0/0/0/0/0", out_valid32, in_ready32, out_ins32, out_imm32, out_pc32);
    end
    rst = 1'b1;
    #1;
    total++; if (in_ready32 !== 1'b1) begin bad++; $display("FAIL rst_full_release_rdy got=%b want=1", in_ready32); end
    out_ready = 1'b1; in_valid = 1'b1; in_ins = 32'h800000B7; in_pc = 32'h5000;
    tick;
    in_valid = 1'b0;
    total++; if (out_valid32 !== 1'b1 || out_ins32 !== 32'h800000B7 || out_imm32 !== 32'h80000000 || out_imm64 !== 64'hFFFFFFFF80000000 || out_type32 !== 3'd4) begin
      bad++; $display("FAIL rst_full_new_entry valid=%b ins=%h imm=%h imm64=%h type=%0d want 1/800000b7/80000000/ffffffff80000000/4",
                      out_valid32, out_ins32, out_imm32, out_imm64, out_type32);
    end
    tick;
    total++; if (out_valid32 !== 1'b0) begin bad++; $display("FAIL rst_full_drain got=%b want=0", out_valid32); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_decode;
    test_backpressure;
    test_flush;
    test_reset_full;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
